// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned LATENCY_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Wide enough for the largest legal LATENCY (15).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/load-store ports plus the memory command/response bus.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_req;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic [DATA_W-1:0]   m_rdata;

  logic busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_be, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_be, busy
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Loadable down-counter timing the fixed memory latency; done marks the capture cycle.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic done
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= CNT_W'(LATENCY - 1);
    else if (run && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = run && (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one fixed-latency memory; data wins unless fetch is starving.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LATENCY    = LATENCY_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned STRK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_MAX);

  arb_state_e state, next_state;
  logic done;
  logic i_gnt, d_gnt, m_req, m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic                owner, we_q;
  logic [STRK_W-1:0]   streak;
  logic                i_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (i_gnt || d_gnt) next_state = ST_WAIT;
      ST_WAIT: if (done)           next_state = ST_IDLE;
      default:                     next_state = ST_IDLE;
    endcase
  end

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    if (rst_n && state == ST_IDLE) begin
      if (bus.d_req && !(bus.i_req && streak == STRK_MAX)) begin
        d_gnt  = 1'b1;
        m_req  = 1'b1;
        m_we   = bus.d_we;
        m_addr = bus.d_addr;
        if (bus.d_we) begin
          m_wdata = bus.d_wdata;
          m_be    = bus.d_be;
        end
      end else if (bus.i_req) begin
        i_gnt  = 1'b1;
        m_req  = 1'b1;
        m_addr = bus.i_addr;
      end
    end
  end

  mem_arb_timer #(.LATENCY(LATENCY)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (i_gnt | d_gnt),
    .run   (state == ST_WAIT),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_I;
      we_q       <= 1'b0;
      streak     <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      if (i_gnt) begin
        owner <= OWN_I;
        we_q  <= 1'b0;
      end
      if (d_gnt) begin
        owner <= OWN_D;
        we_q  <= bus.d_we;
      end
      if (done) begin
        if (owner == OWN_D) begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= we_q ? '0 : bus.m_rdata;
        end else begin
          i_rvalid_q <= 1'b1;
          i_rdata_q  <= bus.m_rdata;
        end
      end
      // Streak counts data wins that made a waiting fetch stand aside.
      if (state == ST_IDLE) begin
        if (i_gnt)
          streak <= '0;
        else if (d_gnt && bus.i_req)
          streak <= (streak == STRK_MAX) ? streak : streak + 1'b1;
        else if (!bus.i_req)
          streak <= '0;
      end
    end
  end

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.m_req    = m_req;
  assign bus.m_we     = m_we;
  assign bus.m_addr   = m_addr;
  assign bus.m_wdata  = m_wdata;
  assign bus.m_be     = m_be;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.busy     = (state == ST_WAIT);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned L  = 2;
  localparam int unsigned SM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_MAX(SM)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic drive_edge;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0; bus.m_rdata = '0;
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_be = '0; bus1.m_rdata = '0;
  endtask

  function automatic logic [6:0] flags0;
    return {bus.i_gnt, bus.d_gnt, bus.m_req, bus.m_we, bus.busy, bus.i_rvalid, bus.d_rvalid};
  endfunction

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    bus.i_req = 1; bus.d_req = 1; bus.i_addr = 32'h10; bus.d_addr = 32'h20;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0) begin miscompares++; $display("FAIL reset_flags got=%b exp=0000000", flags0()); end
    vectors++; if (bus.m_addr !== 32'h0 || bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_data m_addr=%h i_rdata=%h d_rdata=%h exp=0", bus.m_addr, bus.i_rdata, bus.d_rdata); end
    clear_inputs();
    drive_edge(); rst_n = 1;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0) begin miscompares++; $display("FAIL reset_release got=%b exp=0000000", flags0()); end
  endtask

  task automatic test_fetch_only;
    drive_edge(); bus.i_req = 1; bus.i_addr = 32'h4;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b1010000) begin miscompares++; $display("FAIL fetch_grant got=%b exp=1010000", flags0()); end
    vectors++; if (bus.m_addr !== 32'h4) begin miscompares++; $display("FAIL fetch_maddr got=%h exp=00000004", bus.m_addr); end
    drive_edge(); bus.i_req = 0;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0000100) begin miscompares++; $display("FAIL fetch_wait1 got=%b exp=0000100", flags0()); end
    drive_edge(); bus.m_rdata = 32'h00500093;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0000100) begin miscompares++; $display("FAIL fetch_wait2 got=%b exp=0000100", flags0()); end
    drive_edge(); bus.m_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0000010) begin miscompares++; $display("FAIL fetch_rvalid got=%b exp=0000010", flags0()); end
    vectors++; if (bus.i_rdata !== 32'h00500093) begin miscompares++; $display("FAIL fetch_rdata got=%h exp=00500093", bus.i_rdata); end
    drive_edge();
    @(negedge clk);
    vectors++; if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h00500093) begin
      miscompares++; $display("FAIL fetch_hold rvalid=%b rdata=%h exp=0/00500093", bus.i_rvalid, bus.i_rdata); end
  endtask

  task automatic test_priority;
    drive_edge(); bus.i_req = 1; bus.i_addr = 32'h8; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0110000 || bus.m_addr !== 32'h100) begin
      miscompares++; $display("FAIL prio_dgnt flags=%b addr=%h exp=0110000/00000100", flags0(), bus.m_addr); end
    drive_edge(); bus.d_req = 0;
    @(negedge clk);
    drive_edge(); bus.m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0000100) begin miscompares++; $display("FAIL prio_wait got=%b exp=0000100", flags0()); end
    drive_edge(); bus.m_rdata = 32'h0;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b1010001 || bus.m_addr !== 32'h8) begin
      miscompares++; $display("FAIL prio_igrant flags=%b addr=%h exp=1010001/00000008", flags0(), bus.m_addr); end
    vectors++; if (bus.d_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL prio_drdata got=%h exp=deadbeef", bus.d_rdata); end
    drive_edge(); bus.i_req = 0;
    @(negedge clk);
    drive_edge(); bus.m_rdata = 32'h11111111;
    @(negedge clk);
    drive_edge(); bus.m_rdata = 32'h0;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0000010 || bus.i_rdata !== 32'h11111111) begin
      miscompares++; $display("FAIL prio_irvalid flags=%b rdata=%h exp=0000010/11111111", flags0(), bus.i_rdata); end
  endtask

  task automatic test_starvation;
    bit exp_d, exp_i;
    drive_edge(); @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      drive_edge(); bus.i_req = 1; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300; bus.i_addr = 32'h30;
      @(negedge clk);
      exp_d = (k == 0 || k == 3 || k == 6 || k == 9 || k == 15);
      exp_i = (k == 12);
      vectors++; if (bus.d_gnt !== exp_d || bus.i_gnt !== exp_i) begin
        miscompares++; $display("FAIL starve_k%0d d_gnt=%b i_gnt=%b exp=%b/%b", k, bus.d_gnt, bus.i_gnt, exp_d, exp_i); end
    end
    drive_edge(); bus.i_req = 0; bus.d_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write;
    drive_edge(); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0111000 || bus.m_addr !== 32'h200 || bus.m_wdata !== 32'h12345678 || bus.m_be !== 4'b0011) begin
      miscompares++; $display("FAIL write_cmd flags=%b addr=%h wdata=%h be=%b exp=0111000/200/12345678/0011",
        flags0(), bus.m_addr, bus.m_wdata, bus.m_be); end
    drive_edge();
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0000100 || bus.m_wdata !== 32'h0 || bus.m_be !== 4'b0) begin
      miscompares++; $display("FAIL write_busy1 flags=%b wdata=%h be=%b exp=0000100/0/0", flags0(), bus.m_wdata, bus.m_be); end
    drive_edge(); bus.d_req = 0; bus.m_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0000100) begin miscompares++; $display("FAIL write_busy2 got=%b exp=0000100", flags0()); end
    drive_edge(); bus.m_rdata = 32'h0; bus.d_we = 0;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b0000001 || bus.d_rdata !== 32'h0) begin
      miscompares++; $display("FAIL write_ack flags=%b rdata=%h exp=0000001/0", flags0(), bus.d_rdata); end
  endtask

  task automatic test_reset_mid;
    drive_edge(); bus.i_req = 1; bus.i_addr = 32'h40;
    @(negedge clk);
    vectors++; if (bus.i_gnt !== 1'b1) begin miscompares++; $display("FAIL rstmid_grant got=%b exp=1", bus.i_gnt); end
    drive_edge(); rst_n = 0; #1;
    vectors++; if (flags0() !== 7'b0 || bus.m_addr !== 32'h0 || bus.i_rdata !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_zero flags=%b addr=%h irdata=%h exp=0", flags0(), bus.m_addr, bus.i_rdata); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if (bus.i_rvalid !== 1'b0 || bus.i_gnt !== 1'b0) begin
        miscompares++; $display("FAIL rstmid_hold%0d rvalid=%b gnt=%b exp=0/0", k, bus.i_rvalid, bus.i_gnt); end
      if (k < 2) drive_edge();
    end
    drive_edge(); rst_n = 1;
    @(negedge clk);
    vectors++; if (flags0() !== 7'b1010000) begin miscompares++; $display("FAIL rstmid_regrant got=%b exp=1010000", flags0()); end
    drive_edge(); bus.i_req = 0;
    @(negedge clk);
    drive_edge(); bus.m_rdata = 32'hCAFEF00D;
    @(negedge clk);
    vectors++; if (bus.i_rvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_norv got=%b exp=0", bus.i_rvalid); end
    drive_edge(); bus.m_rdata = 32'h0;
    @(negedge clk);
    vectors++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL rstmid_resp rvalid=%b rdata=%h exp=1/cafef00d", bus.i_rvalid, bus.i_rdata); end
  endtask

  task automatic test_back_to_back;
    logic prev_mreq;
    logic [31:0] cap, rd;
    bit exp_g, exp_rv;
    prev_mreq = 0; cap = '0;
    drive_edge(); @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      drive_edge(); bus1.i_req = 1; bus1.i_addr = 32'h80; rd = $urandom; bus1.m_rdata = rd;
      @(negedge clk);
      exp_g  = (k % 2 == 0);
      exp_rv = (k >= 2) && (k % 2 == 0);
      vectors++; if (bus1.i_gnt !== exp_g || bus1.m_req !== exp_g || bus1.i_rvalid !== exp_rv) begin
        miscompares++; $display("FAIL b2b_k%0d gnt=%b mreq=%b rv=%b exp=%b/%b/%b", k, bus1.i_gnt, bus1.m_req, bus1.i_rvalid, exp_g, exp_g, exp_rv); end
      vectors++; if (prev_mreq && bus1.m_req) begin
        miscompares++; $display("FAIL b2b_consec_k%0d m_req=%b exp=0", k, bus1.m_req); end
      if (exp_rv) begin
        vectors++; if (bus1.i_rdata !== cap) begin miscompares++; $display("FAIL b2b_rdata_k%0d got=%h exp=%h", k, bus1.i_rdata, cap); end
      end
      if (k % 2 == 1) cap = rd;
      prev_mreq = bus1.m_req;
    end
    drive_edge(); bus1.i_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random(input int unsigned n);
    int unsigned free_at, cap_at, resp_at, streak;
    bit pend, p_own, p_we, pi, pd, gi, gd, idle, ev_i, ev_d;
    logic [31:0] p_val, i_last, d_last, e_addr, e_wd;
    logic [3:0] e_be;
    logic [6:0] e_f;
    clear_inputs();
    drive_edge(); rst_n = 0;
    drive_edge(); rst_n = 1;
    free_at = 0; cap_at = 0; resp_at = 0; streak = 0; pend = 0; p_own = 0; p_we = 0;
    pi = 0; pd = 0; p_val = '0; i_last = '0; d_last = '0;
    for (int unsigned c = 0; c < n; c++) begin
      drive_edge();
      if (bus.i_req && pi) begin
        bus.i_req = 1'($urandom_range(0, 1)); bus.i_addr = $urandom & 32'h0000_0FFC;
      end else if (bus.i_req) begin
        if ($urandom_range(0, 7) == 0) bus.i_req = 0;
      end else begin
        bus.i_req = ($urandom_range(0, 2) == 0); bus.i_addr = $urandom & 32'h0000_0FFC;
      end
      if (bus.d_req && pd || !bus.d_req) begin
        bus.d_req = ($urandom_range(0, 1) == 0); bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = $urandom & 32'h0000_0FFC; bus.d_wdata = $urandom; bus.d_be = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 7) == 0) bus.d_req = 0;
      bus.m_rdata = $urandom;
      @(negedge clk);
      ev_i = 0; ev_d = 0;
      if (pend && c == resp_at) begin
        if (p_own) begin d_last = p_val; ev_d = 1; end
        else       begin i_last = p_val; ev_i = 1; end
        pend = 0;
      end
      idle = (c >= free_at);
      gd = idle && bus.d_req && !(bus.i_req && streak == SM);
      gi = idle && !gd && bus.i_req;
      e_addr = gd ? bus.d_addr : (gi ? bus.i_addr : 32'h0);
      e_wd   = (gd && bus.d_we) ? bus.d_wdata : 32'h0;
      e_be   = (gd && bus.d_we) ? bus.d_be : 4'h0;
      e_f    = {gi, gd, gi | gd, gd & bus.d_we, !idle, ev_i, ev_d};
      vectors++; if (flags0() !== e_f) begin miscompares++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, flags0(), e_f); end
      vectors++; if (bus.m_addr !== e_addr || bus.m_wdata !== e_wd || bus.m_be !== e_be) begin
        miscompares++; $display("FAIL rnd_cmd c=%0d got=%h/%h/%b exp=%h/%h/%b", c, bus.m_addr, bus.m_wdata, bus.m_be, e_addr, e_wd, e_be); end
      vectors++; if (bus.i_rdata !== i_last || bus.d_rdata !== d_last) begin
        miscompares++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, bus.i_rdata, bus.d_rdata, i_last, d_last); end
      if (pend && c == cap_at) p_val = p_we ? 32'h0 : bus.m_rdata;
      if (gi || gd) begin
        pend = 1; p_own = gd; p_we = gd && bus.d_we;
        cap_at = c + L; resp_at = c + L + 1; free_at = c + L + 1;
      end
      if (idle) begin
        if (gi) streak = 0;
        else if (gd && bus.i_req) streak = (streak < SM) ? streak + 1 : streak;
        else if (!bus.i_req) streak = 0;
      end
      pi = gi; pd = gd;
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_write();
    test_reset_mid();
    test_back_to_back();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
